// File: rtl/mmcm_drp_ctrl_if.sv
// mmcm_drp_ctrl_if: DRP bus between the reconfiguration controller (master) and the MMCM DRP port (slave)
interface mmcm_drp_ctrl_if;
  logic        o_drp_den;
  logic        o_drp_dwe;
  logic [6:0]  o_drp_daddr;
  logic [15:0] o_drp_di;
  logic [15:0] i_drp_do;
  logic        i_drp_drdy;
  modport master (output o_drp_den, o_drp_dwe, o_drp_daddr, o_drp_di, input i_drp_do, i_drp_drdy);
  modport slave (input o_drp_den, o_drp_dwe, o_drp_daddr, o_drp_di, output i_drp_do, i_drp_drdy);
endinterface

// File: rtl/mmcm_drp_ctrl.sv
// mmcm_drp_ctrl: read-modify-write MMCM DRP reconfiguration sequencer with lock supervision
module mmcm_drp_ctrl #(
  parameter int NUM_REGS     = 8,
  parameter int DRDY_TIMEOUT = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [2:0]            o_tbl_idx,
  input  logic [38:0]           i_tbl_entry,
  mmcm_drp_ctrl_if.master       drp,
  output logic                  o_mmcm_rst,
  input  logic                  i_locked,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_rst
);
  localparam int TMAX = DRDY_TIMEOUT > LOCK_TIMEOUT ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW = $clog2(TMAX + 1);
  typedef enum logic [3:0] {
    IDLE, ASSERT_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, WAIT_LOCK, FINISH
  } state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_lk;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_rdata, r_di;
  logic [6:0]      r_daddr;
  logic            r_rst;
  logic            w_lock, w_drdy_to, w_lock_to, w_last;
  logic [15:0]     w_wdata;
  assign w_lock    = r_lk[1];
  assign w_drdy_to = r_cnt == CW'(DRDY_TIMEOUT - 1);
  assign w_lock_to = r_cnt == CW'(LOCK_TIMEOUT - 1);
  assign w_last    = o_tbl_idx == 3'(NUM_REGS - 1);
  assign w_wdata   = (r_rdata & i_tbl_entry[31:16]) | (i_tbl_entry[15:0] & ~i_tbl_entry[31:16]);
  assign drp.o_drp_den   = r_state == RD_REQ || r_state == WR_REQ;
  assign drp.o_drp_dwe   = r_state == WR_REQ;
  assign drp.o_drp_daddr = r_state == RD_REQ ? i_tbl_entry[38:32] : r_daddr;
  assign drp.o_drp_di    = r_state == WR_REQ ? w_wdata : r_di;
  assign o_busy = r_state != IDLE && r_state != FINISH;
  assign o_done = r_state == FINISH;
  assign o_rst  = r_rst;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:       w_next = i_start ? ASSERT_RST : IDLE;
      ASSERT_RST: w_next = RD_REQ;
      RD_REQ:     w_next = RD_WAIT;
      RD_WAIT:    w_next = drp.i_drp_drdy ? WR_REQ : w_drdy_to ? RELEASE : RD_WAIT;
      WR_REQ:     w_next = WR_WAIT;
      WR_WAIT:    w_next = drp.i_drp_drdy ? NEXT : w_drdy_to ? RELEASE : WR_WAIT;
      NEXT:       w_next = w_last ? RELEASE : RD_REQ;
      RELEASE:    w_next = WAIT_LOCK;
      WAIT_LOCK:  w_next = (w_lock || w_lock_to) ? FINISH : WAIT_LOCK;
      FINISH:     w_next = IDLE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lk       <= '0;
      r_rst      <= 1'b1;
      r_cnt      <= '0;
      r_rdata    <= '0;
      r_di       <= '0;
      r_daddr    <= '0;
      o_tbl_idx  <= '0;
      o_mmcm_rst <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      r_lk  <= {r_lk[0], i_locked};
      r_rst <= r_state != IDLE || !w_lock;
      case (r_state)
        IDLE: if (i_start) o_err <= 1'b0;
        ASSERT_RST: begin
          o_mmcm_rst <= 1'b1;
          o_tbl_idx  <= '0;
        end
        RD_REQ: begin
          r_daddr <= i_tbl_entry[38:32];
          r_cnt   <= '0;
        end
        RD_WAIT: begin
          if (drp.i_drp_drdy) r_rdata <= drp.i_drp_do;
          else if (w_drdy_to) o_err <= 1'b1;
          else r_cnt <= r_cnt + 1'b1;
        end
        WR_REQ: begin
          r_di  <= w_wdata;
          r_cnt <= '0;
        end
        WR_WAIT: begin
          if (!drp.i_drp_drdy && w_drdy_to) o_err <= 1'b1;
          else if (!drp.i_drp_drdy) r_cnt <= r_cnt + 1'b1;
        end
        NEXT: if (!w_last) o_tbl_idx <= o_tbl_idx + 3'd1;
        RELEASE: begin
          o_mmcm_rst <= 1'b0;
          r_cnt      <= '0;
        end
        WAIT_LOCK: begin
          if (!w_lock && w_lock_to) o_err <= 1'b1;
          else if (!w_lock) r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mmcm_drp_ctrl.sv
// tb_mmcm_drp_ctrl: scoreboard bench for the MMCM DRP reconfiguration sequencer
module tb_mmcm_drp_ctrl;
  logic        clk = 0, rst = 1, start = 0;
  logic [2:0]  tbl_idx;
  logic [38:0] tbl_entry;
  logic        mmcm_rst, locked, busy, done, err, orst;
  logic        drdy_en = 1, spur = 0, lock_en = 1, lock_drop = 0, locked_m = 0;
  int          lk_cnt = 0;
  int          n_checks = 0, n_pass = 0;
  logic [24:0] q[$];
  logic        prev_den = 0;
  mmcm_drp_ctrl_if drp();
  mmcm_drp_ctrl #(.NUM_REGS(2), .DRDY_TIMEOUT(8), .LOCK_TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .o_tbl_idx(tbl_idx), .i_tbl_entry(tbl_entry),
    .drp(drp), .o_mmcm_rst(mmcm_rst), .i_locked(locked), .o_busy(busy), .o_done(done),
    .o_err(err), .o_rst(orst));
  always #5 clk = ~clk;
  assign tbl_entry = tbl_idx == 3'd0 ? {7'h08, 16'h1000, 16'h0041} :
                     tbl_idx == 3'd1 ? {7'h14, 16'h0000, 16'h1F1F} : 39'h0;
  assign locked = locked_m & ~lock_drop;
  assign drp.i_drp_do = drp.i_drp_drdy ? 16'hFFFF : 16'h0000;
  always @(posedge clk) drp.i_drp_drdy <= (drp.o_drp_den && drdy_en) || spur;
  always @(posedge clk) begin
    if (mmcm_rst || !lock_en) begin
      locked_m <= 0;
      lk_cnt <= 0;
    end else if (!locked_m) begin
      if (lk_cnt == 4) locked_m <= 1;
      lk_cnt <= lk_cnt + 1;
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) begin
    logic [24:0] got;
    if (!rst) begin
      if (drp.o_drp_den) begin
        chk("den_gap", {31'h0, prev_den}, 0);
        chk("mmcm_rst_during_drp", {31'h0, mmcm_rst}, 1);
        got = {drp.o_drp_dwe ? 2'd2 : 2'd1, drp.o_drp_daddr, drp.o_drp_dwe ? drp.o_drp_di : 16'h0};
        if (q.size() == 0) chk("sb_unexpected_drp", {7'h0, got}, 0);
        else chk("sb_drp", {7'h0, got}, {7'h0, q.pop_front()});
      end
      if (done) begin
        got = {2'd3, 7'h0, 15'h0, err};
        if (q.size() == 0) chk("sb_unexpected_done", {7'h0, got}, 0);
        else chk("sb_done", {7'h0, got}, {7'h0, q.pop_front()});
      end
    end
    prev_den = drp.o_drp_den;
  end
  task automatic push_seq(input logic e);
    q.push_back({2'd1, 7'h08, 16'h0});
    q.push_back({2'd2, 7'h08, 16'h1041});
    q.push_back({2'd1, 7'h14, 16'h0});
    q.push_back({2'd2, 7'h14, 16'h1F1F});
    q.push_back({2'd3, 7'h0, 15'h0, e});
  endtask
  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask
  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk(name, 0, 1);
    @(negedge clk);
  endtask
  task automatic check_reset_vals();
    chk("rst_den", {31'h0, drp.o_drp_den}, 0);
    chk("rst_dwe", {31'h0, drp.o_drp_dwe}, 0);
    chk("rst_daddr", {25'h0, drp.o_drp_daddr}, 0);
    chk("rst_di", {16'h0, drp.o_drp_di}, 0);
    chk("rst_idx", {29'h0, tbl_idx}, 0);
    chk("rst_mmcm_rst", {31'h0, mmcm_rst}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);
    chk("rst_orst", {31'h0, orst}, 1);
  endtask
  initial begin
    int n;
    logic saw_busy;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 0;
    repeat (12) @(negedge clk);
    chk("orst_idle_locked", {31'h0, orst}, 0);
    // nominal two-entry reconfiguration
    push_seq(0);
    pulse_start();
    chk("busy_after_start", {31'h0, busy}, 1);
    wait_done("done_timeout_nominal");
    chk("busy_after_done", {31'h0, busy}, 0);
    chk("err_nominal", {31'h0, err}, 0);
    repeat (10) @(negedge clk);
    // DRP never answers
    drdy_en = 0;
    q.push_back({2'd1, 7'h08, 16'h0});
    q.push_back({2'd3, 7'h0, 15'h0, 1'b1});
    pulse_start();
    n = 0;
    while (!drp.o_drp_den && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!err && n < 30) begin @(negedge clk); n++; end
    chk("drdy_timeout_cycles", n, 9);
    wait_done("done_timeout_drdy");
    chk("mmcm_rst_released", {31'h0, mmcm_rst}, 0);
    chk("err_drdy_sticky", {31'h0, err}, 1);
    drdy_en = 1;
    repeat (12) @(negedge clk);
    // lock never returns
    lock_en = 0;
    push_seq(1);
    pulse_start();
    chk("err_cleared_by_start", {31'h0, err}, 0);
    n = 0;
    while (!mmcm_rst && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (mmcm_rst && n < 60) begin @(negedge clk); n++; end
    n = 0;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk("lock_timeout_cycles", n, 16);
    chk("err_lock", {31'h0, err}, 1);
    repeat (5) @(negedge clk);
    chk("orst_unlocked", {31'h0, orst}, 1);
    lock_en = 1;
    repeat (12) @(negedge clk);
    chk("orst_relocked", {31'h0, orst}, 0);
    // restart and spurious drdy ignored
    push_seq(0);
    pulse_start();
    repeat (4) @(negedge clk);
    start = 1;
    @(negedge clk) start = 0;
    wait_done("done_timeout_restart");
    repeat (3) @(negedge clk);
    spur = 1;
    @(negedge clk) spur = 0;
    repeat (10) @(negedge clk);
    chk("spur_idle_busy", {31'h0, busy}, 0);
    chk("sb_drained_restart", q.size(), 0);
    // reset during WR_WAIT
    q.push_back({2'd1, 7'h08, 16'h0});
    q.push_back({2'd2, 7'h08, 16'h1041});
    pulse_start();
    n = 0;
    while (!(drp.o_drp_den && drp.o_drp_dwe) && n < 20) begin @(negedge clk); n++; end
    drdy_en = 0;
    @(negedge clk) rst = 1;
    @(negedge clk);
    check_reset_vals();
    rst = 0;
    drdy_en = 1;
    repeat (15) @(negedge clk);
    chk("orst_after_reset", {31'h0, orst}, 0);
    push_seq(0);
    pulse_start();
    wait_done("done_timeout_after_reset");
    chk("err_after_reset", {31'h0, err}, 0);
    repeat (10) @(negedge clk);
    // lock glitch while idle
    saw_busy = 0;
    @(negedge clk) lock_drop = 1;
    n = 0;
    while (!orst && n < 3) begin @(negedge clk); n++; saw_busy |= busy; end
    chk("orst_on_lock_loss", {31'h0, orst}, 1);
    repeat (5 - n) begin @(negedge clk); saw_busy |= busy; end
    lock_drop = 0;
    n = 0;
    while (orst && n < 3) begin @(negedge clk); n++; saw_busy |= busy; end
    chk("orst_on_relock", {31'h0, orst}, 0);
    repeat (5) begin @(negedge clk); saw_busy |= busy; end
    chk("busy_during_glitch", {31'h0, saw_busy}, 0);
    chk("sb_drained_end", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
